modport_fifo: RTL and testbench
===============================

# modport_fifo

Synchronous single-clock FIFO, 128-bit data path, with full/empty and programmable almost-full/almost-empty status. Sits between a producer asserting write enables and a consumer asserting read enables; the verification environment drives it through driver and monitor views of the FIFO interface, sampling on the rising clock edge.

## Interface
- DATA_W, 128, data word width
- DEPTH, 16, number of entries (power of two, ≥4)
- ALM_FULL_LVL, 12, o_alm_full asserted when count ≥ this value
- ALM_EMPTY_LVL, 4, o_alm_empty asserted when count ≤ this value

- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, synchronous and active-high (1 = reset), despite the name
- i_wren  in  1  write request
- i_wrdata  in  DATA_W  write data, captured with accepted write
- i_rden  in  1  read request
- o_rddata  out  DATA_W  read data, registered
- o_full  out  1  count == DEPTH
- o_empty  out  1  count == 0
- o_alm_full  out  1  count ≥ ALM_FULL_LVL
- o_alm_empty  out  1  count ≤ ALM_EMPTY_LVL

## Operation
- Storage: DEPTH × DATA_W array, write pointer, read pointer (log2(DEPTH) bits, wrap naturally), count register (log2(DEPTH)+1 bits).
- Write accepted = i_wren & (!o_full | i_rden). Accepted write stores i_wrdata at wr_ptr, wr_ptr+1.
- Read accepted = i_rden & !o_empty. Accepted read loads mem[rd_ptr] into o_rddata, rd_ptr+1.
- Count: +1 write only, −1 read only, unchanged when both or neither accepted.
- Simultaneous write+read when full: both accepted, count stays DEPTH.
- Simultaneous write+read when empty: write accepted, read ignored (no fall-through); count becomes 1.
- Rejected write (full, no read): data dropped, no state change. Rejected read (empty): o_rddata holds last value.
- Status flags are combinational decodes of the count register only (no input dependency).
- Reset: pointers = 0, count = 0, o_rddata = 0; hence o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0. Memory contents not reset. Reset overrides any concurrent i_wren/i_rden; mid-operation reset discards all stored data.

## Timing
- Write-to-read latency: word written at edge N is readable by i_rden sampled at edge N+1; o_rddata valid after the edge that accepts the read (1-cycle read latency).
- Flags change on the same edge that updates count; visible one cycle after the accepting request.
- Order preserved strictly FIFO across pointer wrap-around.
- Inputs sampled at rising edge; bench drives with output skew #1, samples with input skew #1.

## Configuration
- FIFO_ERR_FLAGS_EN defined: adds outputs o_overflow and o_underflow (1 bit each, reset 0). o_overflow pulses high for one cycle after a rejected write; o_underflow pulses high for one cycle after a rejected read.
- Not defined: ports absent; rejected requests silently ignored.

## Test plan
- Reset: hold rstn=1 two cycles with i_wren=1 -> o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0, count 0.
- Fill: 16 writes of 0x1..0x10 -> o_alm_full rises after 12th, o_full after 16th; 17th write (0xDEAD) dropped (o_overflow pulse if enabled).
- Drain: 16 reads -> o_rddata = 0x1..0x10 in order, one cycle after each read; o_empty after last; extra read leaves o_rddata=0x10.
- Wrap: write 10, read 10, repeat 3 times with incrementing data -> all data in order, pointers wrap, no false full/empty.
- Simultaneous at full: i_wren+i_rden with count=16 -> o_rddata = oldest word, o_full stays 1; at empty -> count becomes 1, o_empty drops, o_rddata unchanged.
- Mid-op reset: after 7 writes assert rstn=1 one cycle -> o_empty=1; next write/read returns new data, not stale.

Source files
------------

// File: rtl/modport_fifo_if.sv
// Handshake bundle for modport_fifo. The producer and consumer use the master view, the FIFO uses the slave view, and observers use the monitor view.
// With FIFO_ERR_FLAGS_EN defined, the bundle also carries the o_overflow and o_underflow pulses.
interface modport_fifo_if #(
   parameter int DATA_W = 128
);
   // Request semantics: i_wren and i_rden are sampled at every rising edge.
   // A write is taken when the FIFO is not full, or when a read is accepted in the same cycle.
   // A read is taken when the FIFO is not empty. Requests that are not taken are dropped.
   // Read data appears on o_rddata after the edge that accepts the read.
   logic              i_wren;
   logic [DATA_W-1:0] i_wrdata;
   logic              i_rden;
   logic [DATA_W-1:0] o_rddata;
   logic              o_full;
   logic              o_empty;
   logic              o_alm_full;
   logic              o_alm_empty;
`ifdef FIFO_ERR_FLAGS_EN
   logic              o_overflow;
   logic              o_underflow;
`endif

   modport master (
      output i_wren, i_wrdata, i_rden,
      input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty
`ifdef FIFO_ERR_FLAGS_EN
      , input o_overflow, o_underflow
`endif
   );

   modport slave (
      input  i_wren, i_wrdata, i_rden,
      output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty
`ifdef FIFO_ERR_FLAGS_EN
      , output o_overflow, o_underflow
`endif
   );

   modport monitor (
      input i_wren, i_wrdata, i_rden,
      input o_rddata, o_full, o_empty, o_alm_full, o_alm_empty
`ifdef FIFO_ERR_FLAGS_EN
      , input o_overflow, o_underflow
`endif
   );
endinterface

// File: rtl/modport_fifo.sv
// Synchronous single-clock FIFO with a registered read port and full, empty, almost-full and almost-empty flags decoded from the count register.
// Defining FIFO_ERR_FLAGS_EN adds o_overflow and o_underflow pulses that follow rejected requests.
module modport_fifo #(
   parameter int DATA_W        = 128,
   parameter int DEPTH         = 16,
   parameter int ALM_FULL_LVL  = 12,
   parameter int ALM_EMPTY_LVL = 4
) (
   input logic           clk,
   input logic           rstn,
   modport_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(ALM_FULL_LVL);
   localparam logic [CW-1:0] CNT_AE   = CW'(ALM_EMPTY_LVL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] rddata_q;
   logic              full;
   logic              empty;
   logic              wr_acc;
   logic              rd_acc;

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   // When the FIFO is full, a write is taken only if a read frees a slot in the same cycle.
   // When the FIFO is empty, a read is never taken, so written data does not fall through.
   assign wr_acc = bus.i_wren & (~full | bus.i_rden);
   assign rd_acc = bus.i_rden & ~empty;

   // The storage array has no reset. Writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (!rstn && wr_acc) begin
         mem[wr_ptr] <= bus.i_wrdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rddata_q <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         // On a full write+read, wr_ptr equals rd_ptr. The non-blocking read returns the oldest word before it is overwritten.
         if (rd_acc) begin
            rddata_q <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.o_rddata    = rddata_q;
   assign bus.o_full      = full;
   assign bus.o_empty     = empty;
   assign bus.o_alm_full  = (count >= CNT_AF);
   assign bus.o_alm_empty = (count <= CNT_AE);

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk) begin
      if (rstn) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= bus.i_wren & ~wr_acc;
         underflow_q <= bus.i_rden & ~rd_acc;
      end
   end

   assign bus.o_overflow  = overflow_q;
   assign bus.o_underflow = underflow_q;
`endif
endmodule

// File: tb/tb_modport_fifo.sv
// Testbench for modport_fifo: a table of fill/drain vectors, hand-written corner-case sequences, and randomized traffic.
// All results are checked against a queue-based reference model.
module tb_modport_fifo;
   localparam int DW    = 128;
   localparam int DEPTH = 16;

   typedef struct {
      bit            wren;
      bit            rden;
      logic [DW-1:0] data;
      logic [DW-1:0] exp_rd;
      logic [3:0]    exp_flags;
      bit            exp_ovf;
      bit            exp_udf;
   } vec_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   modport_fifo_if #(.DATA_W(DW)) bus ();

   modport_fifo #(
      .DATA_W(DW), .DEPTH(DEPTH), .ALM_FULL_LVL(12), .ALM_EMPTY_LVL(4)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_rd;
   bit            exp_ovf;
   bit            exp_udf;
   int            n_tests = 0;
   int            n_fail  = 0;
   vec_t          tbl[34];

   // Flag order is {full, empty, alm_full, alm_empty}.
   function automatic logic [3:0] flags_for(int c);
      return {c == DEPTH, c == 0, c >= 12, c <= 4};
   endfunction

   task automatic check_d(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_f(string name, logic [3:0] act, logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_model(string tag);
      check_d({tag, " rddata"}, bus.o_rddata, exp_rd);
      check_f({tag, " flags"}, {bus.o_full, bus.o_empty, bus.o_alm_full, bus.o_alm_empty},
              flags_for(exp_q.size()));
`ifdef FIFO_ERR_FLAGS_EN
      check_f({tag, " err"}, {2'b00, bus.o_overflow, bus.o_underflow}, {2'b00, exp_ovf, exp_udf});
`endif
   endtask

   // Drives one cycle of inputs, advances the reference model, and samples #1 after the edge.
   task automatic step(bit wren, logic [DW-1:0] data, bit rden, bit rst);
      int sz;
      bit wok, rok;
      rstn         = rst;
      bus.i_wren   = wren;
      bus.i_wrdata = data;
      bus.i_rden   = rden;
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         exp_rd  = '0;
         exp_ovf = 1'b0;
         exp_udf = 1'b0;
      end else begin
         sz  = exp_q.size();
         wok = wren && (sz < DEPTH || rden);
         rok = rden && (sz > 0);
         exp_ovf = wren && !wok;
         exp_udf = rden && !rok;
         if (rok) exp_rd = exp_q.pop_front();
         if (wok) exp_q.push_back(data);
      end
   endtask

   initial begin
      rstn = 1'b1; bus.i_wren = 1'b0; bus.i_wrdata = '0; bus.i_rden = 1'b0;
      exp_rd = '0; exp_ovf = 1'b0; exp_udf = 1'b0;

      // Reset: hold rstn high for two cycles with a write request present.
      step(1'b1, DW'(128'hAAAA), 1'b0, 1'b1);
      step(1'b1, DW'(128'hBBBB), 1'b0, 1'b1);
      check_f("reset flags", {bus.o_full, bus.o_empty, bus.o_alm_full, bus.o_alm_empty}, 4'b0101);
      check_d("reset rddata", bus.o_rddata, '0);
      check_model("reset");

      // Fill with 1..16, attempt a 17th write that is dropped, then drain 16 words and issue one extra read.
      for (int i = 0; i < 16; i++)
         tbl[i] = '{1'b1, 1'b0, DW'(i + 1), '0, flags_for(i + 1), 1'b0, 1'b0};
      tbl[16] = '{1'b1, 1'b0, DW'(128'hDEAD), '0, flags_for(16), 1'b1, 1'b0};
      for (int j = 0; j < 16; j++)
         tbl[17 + j] = '{1'b0, 1'b1, '0, DW'(j + 1), flags_for(15 - j), 1'b0, 1'b0};
      tbl[33] = '{1'b0, 1'b1, '0, DW'(128'h10), flags_for(0), 1'b0, 1'b1};
      for (int k = 0; k < 34; k++) begin
         step(tbl[k].wren, tbl[k].data, tbl[k].rden, 1'b0);
         check_model("table model");
         check_d("table rddata", bus.o_rddata, tbl[k].exp_rd);
         check_f("table flags", {bus.o_full, bus.o_empty, bus.o_alm_full, bus.o_alm_empty},
                 tbl[k].exp_flags);
`ifdef FIFO_ERR_FLAGS_EN
         check_f("table err", {2'b00, bus.o_overflow, bus.o_underflow},
                 {2'b00, tbl[k].exp_ovf, tbl[k].exp_udf});
`endif
      end

      // Wrap: three rounds of 10 writes then 10 reads, so the pointers cross the array boundary.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 10; k++) begin
            step(1'b1, DW'(32'h100 + r * 10 + k), 1'b0, 1'b0);
            check_model("wrap wr");
         end
         for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check_model("wrap rd");
            check_d("wrap order", bus.o_rddata, DW'(32'h100 + r * 10 + k));
         end
      end

      // Simultaneous write and read while full.
      for (int k = 0; k < 16; k++) step(1'b1, DW'(32'h200 + k), 1'b0, 1'b0);
      step(1'b1, DW'(32'h300), 1'b1, 1'b0);
      check_d("full both rddata", bus.o_rddata, DW'(32'h200));
      check_f("full both full", {3'b000, bus.o_full}, 4'b0001);
      check_model("full both");
      for (int k = 0; k < 16; k++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         check_model("full drain");
      end
      check_d("drain last", bus.o_rddata, DW'(32'h300));

      // Simultaneous write and read while empty.
      step(1'b1, DW'(32'h400), 1'b1, 1'b0);
      check_f("empty both empty", {3'b000, bus.o_empty}, 4'b0000);
      check_d("empty both rddata", bus.o_rddata, DW'(32'h300));
      check_model("empty both");
      step(1'b0, '0, 1'b1, 1'b0);
      check_d("empty both next", bus.o_rddata, DW'(32'h400));

      // Reset in the middle of operation.
      for (int k = 0; k < 7; k++) step(1'b1, DW'(32'h500 + k), 1'b0, 1'b0);
      step(1'b1, DW'(32'hBAD), 1'b1, 1'b1);
      check_f("midrst flags", {bus.o_full, bus.o_empty, bus.o_alm_full, bus.o_alm_empty}, 4'b0101);
      check_d("midrst rddata", bus.o_rddata, '0);
      step(1'b1, DW'(32'h600), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check_d("midrst new data", bus.o_rddata, DW'(32'h600));
      check_model("midrst");

      // Randomized traffic in phases biased toward writes, then reads, then balanced, with rare resets.
      for (int n = 0; n < 3000; n++) begin
         int wp;
         int rp;
         bit w, r, rs;
         wp = ((n / 250) % 3 == 0) ? 80 : (((n / 250) % 3 == 1) ? 25 : 50);
         rp = 100 - wp;
         w  = ($urandom_range(0, 99) < wp);
         r  = ($urandom_range(0, 99) < rp);
         rs = ($urandom_range(0, 399) == 0);
         step(w, {$urandom(), $urandom(), $urandom(), $urandom()}, r, rs);
         check_model("random");
      end

      rstn = 1'b0; bus.i_wren = 1'b0; bus.i_rden = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
